ov2640_capture: RTL

//  Consumes the OV2640 DVP pixel stream once sensor configuration has finished.

---
 rtl/ov2640_pkg.sv | 20 ++
 rtl/cam_sync.sv | 27 ++
 rtl/ov2640_capture.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ov2640_pkg.sv
// Shared types and constants for the OV2640 DVP capture path.
package ov2640_pkg;

  typedef enum logic [1:0] {
    WAIT_CFG   = 2'd0,
    WAIT_VSYNC = 2'd1,
    CAPTURE    = 2'd2
  } cap_state_t;

  localparam int QVGA_W = 320;
  localparam int QVGA_H = 240;

  // RGB565 layout: R[15:11], G[10:5], B[4:0]
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchroniser for a bundle of camera signals into the clk domain.
module cam_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Metastability chain; every bit sees the same two-stage delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/ov2640_capture.sv
// OV2640 DVP capture: synchronises the camera bus, packs byte pairs into
// RGB565 and emits one frame-buffer write per stored pixel.
module ov2640_capture
  import ov2640_pkg::*;
#(
  parameter int H_ACTIVE = QVGA_W,
  parameter int V_ACTIVE = QVGA_H,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              config_done,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 2);
  localparam logic [XW-1:0]     X_MAX     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX     = YW'(V_ACTIVE);
  localparam logic [YW-1:0]     Y_SAT     = YW'(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  logic [10:0] w_sync_d;
  logic [10:0] w_sync_q;
  logic        w_pclk_s2;
  logic        w_vsync_s2;
  logic        w_href_s2;
  logic [7:0]  w_data_s2;
  logic        w_pe;
  logic        w_vs_fall;
  logic        w_vs_rise;
  logic        w_href_fall;

  logic        r_pclk_s3;
  logic        r_vsync_s3;
  logic        r_href_s3;

  cap_state_t        r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_line_base;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic              r_pix_valid;
  rgb565_t           r_pix_data;
  logic [ADDR_W-1:0] r_pix_addr;
  logic              r_frame_done;
  logic              r_frame_err;
  logic              r_busy;

  assign w_sync_d = {cam_pclk, cam_vsync, cam_href, cam_data};

  cam_sync #(.W(11)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (w_sync_d),
    .o_q (w_sync_q)
  );

  assign w_pclk_s2   = w_sync_q[10];
  assign w_vsync_s2  = w_sync_q[9];
  assign w_href_s2   = w_sync_q[8];
  assign w_data_s2   = w_sync_q[7:0];

  // Data, href and vsync all come from s2 so they line up with the pclk edge.
  assign w_pe        = w_pclk_s2 & ~r_pclk_s3;
  assign w_vs_fall   = ~w_vsync_s2 & r_vsync_s3;
  assign w_vs_rise   = w_vsync_s2 & ~r_vsync_s3;
  assign w_href_fall = ~w_href_s2 & r_href_s3;

  // Third flop on the synchronised control lines for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pclk_s3  <= 1'b0;
      r_vsync_s3 <= 1'b0;
      r_href_s3  <= 1'b0;
    end else begin
      r_pclk_s3  <= w_pclk_s2;
      r_vsync_s3 <= w_vsync_s2;
      r_href_s3  <= w_href_s2;
    end
  end

  // Frame FSM with byte packer, line/column counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_CFG;
      r_x          <= '0;
      r_y          <= '0;
      r_line_base  <= '0;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_addr   <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (!config_done) begin
        r_state <= WAIT_CFG;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          WAIT_CFG: r_state <= WAIT_VSYNC;
          WAIT_VSYNC: begin
            if (w_vs_fall && capture_en) begin
              r_state     <= CAPTURE;
              r_busy      <= 1'b1;
              r_x         <= '0;
              r_y         <= '0;
              r_line_base <= '0;
              r_phase     <= 1'b0;
              r_frame_err <= 1'b0;
            end
          end
          CAPTURE: begin
            if (w_pe && w_href_s2) begin
              if (!r_phase) begin
                r_hi    <= w_data_s2;
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (r_x < X_MAX && r_y < Y_MAX) begin
                  r_pix_valid <= 1'b1;
                  r_pix_data  <= rgb565_t'({r_hi, w_data_s2});
                  r_pix_addr  <= r_line_base + ADDR_W'(r_x);
                end
                if (r_x < X_MAX) r_x <= r_x + XW'(1);
              end
            end
            // Line end: odd byte count or a short non-empty line is an error;
            // empty lines leave y untouched.
            if (w_href_fall) begin
              if (r_phase || (r_x != '0 && r_x < X_MAX)) r_frame_err <= 1'b1;
              if (r_x != '0 && r_y < Y_SAT) begin
                r_y         <= r_y + YW'(1);
                r_line_base <= r_line_base + LINE_STEP;
              end
              r_x     <= '0;
              r_phase <= 1'b0;
            end
            if (w_vs_rise) begin
              r_frame_done <= 1'b1;
              if (r_y != Y_MAX) r_frame_err <= 1'b1;
              r_state <= WAIT_VSYNC;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= WAIT_CFG;
        endcase
      end
    end
  end

  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_addr   = r_pix_addr;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule
